// File: rtl/padded_frame_ctrl_pkg.sv
// Shared types and geometry helpers for the padded frame controller.
// Holds FSM states, channel codes and padded-size/address-width derivation.
package padded_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  function automatic int pad_w(input int w);
    return w + 2;
  endfunction

  function automatic int pad_h(input int h);
    return h + 2;
  endfunction

  function automatic int addr_w(input int w, input int h);
    return $clog2(pad_w(w) * pad_h(h));
  endfunction

endpackage

// File: rtl/padded_frame_ctrl_if.sv
// Handshake/bus bundle between the controller and its load/scan neighbours.
// master: controller side (drives strobes/addresses); slave: environment side.
interface padded_frame_ctrl_if
  import padded_frame_ctrl_pkg::*;
#(
  parameter int WIDTH  = 400,
  parameter int HEIGHT = 300
);
  localparam int AW = addr_w(WIDTH, HEIGHT);

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [1:0]    wr_chan;
  logic [AW-1:0] wr_addr;
  logic          out_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [3:0]    tap;
  logic          win_last;
  logic          busy;
  logic          done;

  modport master (
    input  start, in_valid, out_ready,
    output in_ready, wr_en, wr_chan, wr_addr,
    output rd_en, rd_addr, tap, win_last,
    output busy, done
  );

  modport slave (
    output start, in_valid, out_ready,
    input  in_ready, wr_en, wr_chan, wr_addr,
    input  rd_en, rd_addr, tap, win_last,
    input  busy, done
  );

endinterface

// File: rtl/padded_frame_ctrl_window_addr_gen.sv
// 3x3 window read-address generator over the padded buffer.
// Ports: clk, reset, init_i (load first center), adv_i (read taken),
// rd_addr_o/tap_o (registered, stable while stalled), last_o (final tap).
module window_addr_gen
  import padded_frame_ctrl_pkg::*;
#(
  parameter int WIDTH  = 400,
  parameter int HEIGHT = 300,
  localparam int AW    = addr_w(WIDTH, HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init_i,
  input  logic          adv_i,
  output logic [AW-1:0] rd_addr_o,
  output logic [3:0]    tap_o,
  output logic          last_o
);
  localparam int PW = pad_w(WIDTH);
  localparam logic [AW-1:0] FIRST = AW'(PW + 1);
  localparam logic [AW-1:0] ROW1  = AW'(PW);
  localparam logic [AW-1:0] ROW2  = AW'(2 * PW);
  localparam logic [AW-1:0] LASTC = AW'(WIDTH);
  localparam logic [AW-1:0] LASTR = AW'(HEIGHT);

  logic [AW-1:0] center_q, center_d;
  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] col_q, col_d;
  logic [1:0]    tr_q, tr_d;
  logic [1:0]    tc_q, tc_d;
  logic [3:0]    tap_q, tap_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] row_off;

  always_comb begin
    center_d = center_q;
    row_d    = row_q;
    col_d    = col_q;
    tr_d     = tr_q;
    tc_d     = tc_q;
    tap_d    = tap_q;
    if (init_i) begin
      center_d = FIRST;
      row_d    = AW'(1);
      col_d    = AW'(1);
      tr_d     = 2'd0;
      tc_d     = 2'd0;
      tap_d    = 4'd0;
    end else if (adv_i) begin
      if (tap_q == 4'd8) begin
        tap_d = 4'd0;
        tr_d  = 2'd0;
        tc_d  = 2'd0;
        // end of row: hop over right pad and next left pad
        if (col_q == LASTC) begin
          col_d    = AW'(1);
          row_d    = row_q + AW'(1);
          center_d = center_q + AW'(3);
        end else begin
          col_d    = col_q + AW'(1);
          center_d = center_q + AW'(1);
        end
      end else begin
        tap_d = tap_q + 4'd1;
        if (tc_q == 2'd2) begin
          tc_d = 2'd0;
          tr_d = tr_q + 2'd1;
        end else begin
          tc_d = tc_q + 2'd1;
        end
      end
    end
    row_off = '0;
    unique case (1'b1)
      (tr_d == 2'd1): row_off = ROW1;
      (tr_d == 2'd2): row_off = ROW2;
      default: ;
    endcase
    // top-left neighbour is center-(PW+1); center >= PW+1 so no wrap
    rd_addr_d = center_d - FIRST + row_off
              + {{(AW-2){1'b0}}, tc_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      center_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      tr_q      <= '0;
      tc_q      <= '0;
      tap_q     <= '0;
      rd_addr_q <= '0;
    end else begin
      center_q  <= center_d;
      row_q     <= row_d;
      col_q     <= col_d;
      tr_q      <= tr_d;
      tc_q      <= tc_d;
      tap_q     <= tap_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign rd_addr_o = rd_addr_q;
  assign tap_o     = tap_q;
  assign last_o    = (tap_q == 4'd8) && (row_q == LASTR)
                  && (col_q == LASTC);

endmodule

// File: rtl/padded_frame_ctrl.sv
// Loads RGB nibbles into a zero-padded frame buffer, then scans 3x3 windows.
// Ports: clk, reset (async, active-high), bus (padded_frame_ctrl_if.master).
module padded_frame_ctrl
  import padded_frame_ctrl_pkg::*;
#(
  parameter int WIDTH  = 400,
  parameter int HEIGHT = 300
) (
  input logic clk,
  input logic reset,
  padded_frame_ctrl_if.master bus
);
  localparam int PW = pad_w(WIDTH);
  localparam int AW = addr_w(WIDTH, HEIGHT);
  localparam logic [AW-1:0] FIRST   = AW'(PW + 1);
  localparam logic [AW-1:0] NPIX_M1 = AW'(WIDTH * HEIGHT - 1);
  localparam logic [AW-1:0] COL_M1  = AW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [AW-1:0] col_q, col_d;
  chan_e         chan_q, chan_d;

  logic          in_ready;
  logic          busy;
  logic          done;
  logic          wr_en;
  logic          rd_en;
  logic          init;
  logic          pix_last;
  logic          scan_last;
  logic          win_end;
  logic [AW-1:0] rd_addr;
  logic [3:0]    tap;

  assign wr_en    = bus.in_valid & in_ready;
  assign rd_en    = (state_q == S_SCAN) & bus.out_ready;
  assign init     = (state_q == S_IDLE) & bus.start;
  assign pix_last = wr_en & (chan_q == CH_B)
                  & (pix_q == NPIX_M1);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (pix_last) state_d = S_SCAN;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (scan_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_addr_d = wr_addr_q;
    pix_d     = pix_q;
    col_d     = col_q;
    chan_d    = chan_q;
    if (init) begin
      wr_addr_d = FIRST;
      pix_d     = '0;
      col_d     = '0;
      chan_d    = CH_R;
    end else if (wr_en) begin
      if (chan_q == CH_B) begin
        chan_d = CH_R;
        pix_d  = pix_q + AW'(1);
        // last column: skip right pad and next row's left pad
        if (col_q == COL_M1) begin
          col_d     = '0;
          wr_addr_d = wr_addr_q + AW'(3);
        end else begin
          col_d     = col_q + AW'(1);
          wr_addr_d = wr_addr_q + AW'(1);
        end
      end else begin
        chan_d = chan_e'(chan_q + 2'd1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      pix_q     <= '0;
      col_q     <= '0;
      chan_q    <= CH_R;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      pix_q     <= pix_d;
      col_q     <= col_d;
      chan_q    <= chan_d;
    end
  end

  window_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_win (
    .clk       (clk),
    .reset     (reset),
    .init_i    (init),
    .adv_i     (rd_en),
    .rd_addr_o (rd_addr),
    .tap_o     (tap),
    .last_o    (win_end)
  );

  assign scan_last = rd_en & win_end;

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en;
  assign bus.wr_chan  = chan_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.rd_en    = rd_en;
  assign bus.rd_addr  = rd_addr;
  assign bus.tap      = tap;
  assign bus.win_last = rd_en & (tap == 4'd8);
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule

// File: tb/tb_padded_frame_ctrl.sv
// Directed bench for padded_frame_ctrl at WIDTH=4, HEIGHT=3 (PW=6).
// Checks load addressing, window scan order, stalls, done and async reset.
module tb_padded_frame_ctrl;
  logic clk;
  logic reset;
  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int pad_cnt = 0;
  int q_addr[$];
  int q_tap[$];
  int q_last[$];
  int exp_px[12] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22};
  int exp_w0[9]  = '{0, 1, 2, 6, 7, 8, 12, 13, 14};

  padded_frame_ctrl_if #(.WIDTH(4), .HEIGHT(3)) bus ();

  padded_frame_ctrl #(.WIDTH(4), .HEIGHT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit is_pad(input int a);
    int r;
    int c;
    r = a / 6;
    c = a % 6;
    return (r == 0) || (r == 4) || (c == 0) || (c == 5);
  endfunction

  always @(posedge clk) begin
    if (bus.wr_en) begin
      wr_cnt++;
      if (is_pad(int'(bus.wr_addr))) pad_cnt++;
    end
    if (bus.rd_en) begin
      q_addr.push_back(int'(bus.rd_addr));
      q_tap.push_back(int'(bus.tap));
      q_last.push_back(int'(bus.win_last));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    wr_cnt = 0;
    pad_cnt = 0;
    q_addr.delete();
    q_tap.delete();
    q_last.delete();
    bus.out_ready = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    chk("idle_wr_en", 32'(bus.wr_en), 0);
    chk("idle_busy", 32'(bus.busy), 0);
    tick();
    bus.start = 1'b1;
    #1;
    chk("start_in_ready", 32'(bus.in_ready), 0);
    chk("start_wr_en", 32'(bus.wr_en), 0);
    tick();
    bus.start = 1'b0;
    chk("load_busy", 32'(bus.busy), 1);
  endtask

  task automatic load(input bit gaps);
    int n;
    bit v;
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 36; cyc++) begin
      v = gaps ? (cyc % 4 != 2) : 1'b1;
      if (gaps) bus.start = 1'b1;
      bus.in_valid = v;
      #1;
      if (v) begin
        chk("wr_en", 32'(bus.wr_en), 1);
        chk("wr_addr", 32'(bus.wr_addr), exp_px[n / 3]);
        chk("wr_chan", 32'(bus.wr_chan), n % 3);
        n++;
      end else begin
        chk("gap_wr_en", 32'(bus.wr_en), 0);
      end
      tick();
    end
    chk("load_count", n, 36);
    bus.start = 1'b0;
    chk("scan_busy", 32'(bus.busy), 1);
    chk("scan_in_ready", 32'(bus.in_ready), 0);
  endtask

  task automatic scan(input bit rnd);
    bit seen;
    bit o;
    logic [31:0] pt;
    logic [31:0] pa;
    int c;
    int t;
    int ctr;
    seen = 1'b0;
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      o = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = o;
      #1;
      pt = 32'(bus.tap);
      pa = 32'(bus.rd_addr);
      chk("scan_rd_en", 32'(bus.rd_en), 32'(o));
      tick();
      if (!o) begin
        chk("stall_tap", 32'(bus.tap), pt);
        chk("stall_addr", 32'(bus.rd_addr), pa);
      end
    end
    chk("done_seen", 32'(seen), 1);
    chk("done_busy", 32'(bus.busy), 0);
    tick();
    chk("done_pulse_len", 32'(bus.done), 0);
    chk("idle_busy_after", 32'(bus.busy), 0);
    chk("idle_rd_en", 32'(bus.rd_en), 0);
    bus.in_valid = 1'b0;
    chk("n_reads", q_addr.size(), 108);
    for (int i = 0; i < 9 && i < q_addr.size(); i++)
      chk("w0_addr", q_addr[i], exp_w0[i]);
    for (int k = 0; k < q_addr.size() && k < 108; k++) begin
      c = k / 9;
      t = k % 9;
      ctr = (c / 4 + 1) * 6 + (c % 4) + 1;
      chk("rd_addr", q_addr[k], ctr - 7 + (t / 3) * 6 + (t % 3));
      chk("rd_tap", q_tap[k], t);
      chk("rd_last", q_last[k], (t == 8) ? 1 : 0);
    end
    if (q_addr.size() > 0) begin
      chk("final_addr", q_addr[q_addr.size() - 1], 29);
      chk("final_last", q_last[q_last.size() - 1], 1);
    end
    chk("n_writes", wr_cnt, 36);
    chk("pad_writes", pad_cnt, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_rd_en", 32'(bus.rd_en), 0);
    chk("rst_win_last", 32'(bus.win_last), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_wr_chan", 32'(bus.wr_chan), 0);
    chk("rst_tap", 32'(bus.tap), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 0);
    reset = 1'b0;
    tick();

    start_frame();
    load(1'b0);
    scan(1'b0);

    start_frame();
    load(1'b1);
    scan(1'b1);

    start_frame();
    load(1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.tap == 4'd4) break;
      tick();
    end
    chk("mid_tap", 32'(bus.tap), 4);
    chk("mid_rd_en", 32'(bus.rd_en), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_rd_en", 32'(bus.rd_en), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_tap", 32'(bus.tap), 0);
    chk("arst_rd_addr", 32'(bus.rd_addr), 0);
    chk("arst_wr_addr", 32'(bus.wr_addr), 0);
    chk("arst_win_last", 32'(bus.win_last), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 0);
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    tick();

    start_frame();
    load(1'b0);
    scan(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
